// File: rtl/up_debug_monitor_pkg.sv
// Shared types and helpers for the up3 debug monitor.
//   run_state_e : clock-enable FSM states
//   SEG_BLANK   : active-low pattern with every segment off
//   hex_to_seg  : nibble to active-low 7-segment pattern (bit 6 = g .. bit 0 = a)
//   num_pages   : number of three-channel display pages for a channel count
//   page_w      : width of the page register (at least 1 bit)
package up_dbg_pkg;

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    STEP  = 2'd1,
    RUN   = 2'd2,
    BREAK = 2'd3
  } run_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  function automatic int num_pages(input int nch);
    return (nch + 2) / 3;
  endfunction

  function automatic int page_w(input int nch);
    int np;
    np = num_pages(nch);
    return (np > 1) ? $clog2(np) : 1;
  endfunction

endpackage

// File: rtl/up_debug_monitor_if.sv
// Board/core signal bundle of the debug monitor.
//   master : the monitor (reads buttons, probes, pc, flags; drives cpu_en,
//            page, ledr and the six HEX digits)
//   slave  : the board and processor side of the same wires
interface up_debug_monitor_if
  import up_dbg_pkg::*;
#(
  parameter int NUM_CH = 6
);
  localparam int PAGE_W = page_w(NUM_CH);

  logic                  btn_step;
  logic                  btn_run;
  logic                  btn_page;
  logic                  bp_en;
  logic [7:0]            bp_addr;
  logic [7:0]            pc;
  logic [NUM_CH*8-1:0]   probe;
  logic [7:0]            flags;
  logic                  cpu_en;
  logic [PAGE_W-1:0]     page;
  logic [9:0]            ledr;
  logic [6:0]            hex0, hex1, hex2, hex3, hex4, hex5;

  modport master (
    input  btn_step, btn_run, btn_page, bp_en, bp_addr, pc, probe, flags,
    output cpu_en, page, ledr, hex0, hex1, hex2, hex3, hex4, hex5
  );

  modport slave (
    output btn_step, btn_run, btn_page, bp_en, bp_addr, pc, probe, flags,
    input  cpu_en, page, ledr, hex0, hex1, hex2, hex3, hex4, hex5
  );

endinterface

// File: rtl/up_debug_monitor_btn.sv
// Push-button conditioner: 2-flop synchroniser, stability-count debouncer
// and rising-edge pulse.
//   clk, reset : system clock, synchronous active-high reset
//   raw        : asynchronous button input, active-high
//   level      : debounced level
//   pulse      : one-cycle pulse on each debounced rising edge
// A clean raw rise yields the pulse DEB_CYCLES+2 cycles later.
module btn_conditioner #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic             sync_p0, sync_p1;
  logic             level_p2, level_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0  <= 1'b0;
      sync_p1  <= 1'b0;
      level_p2 <= 1'b0;
      level_d  <= 1'b0;
      cnt      <= '0;
    end else begin
      // stage p0/p1: metastability synchroniser
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      // stage p2: accept a new level only after DEB_CYCLES consecutive
      // disagreeing samples; any agreeing sample restarts the count
      level_d <= level_p2;
      if (sync_p1 == level_p2) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
        level_p2 <= sync_p1;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign level = level_p2;
  assign pulse = level_p2 & ~level_d;

endmodule

// File: rtl/up_debug_monitor.sv
// Board-level debug monitor for the up3 processor.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : up_debug_monitor_if.master
//     btn_step/btn_run/btn_page : raw buttons
//     bp_en, bp_addr, pc        : breakpoint on PC match at RUN candidates
//     probe, flags              : values shown on HEX digits / LEDs
//     cpu_en                    : registered processor clock enable
//     page                      : current display page
//     ledr                      : {running, bp_hit, flags}
//     hex5..hex0                : left/middle/right channel, active-low
module up_debug_monitor
  import up_dbg_pkg::*;
#(
  parameter int NUM_CH     = 6,
  parameter int DEB_CYCLES = 50000,
  parameter int RUN_DIV    = 1
) (
  input  logic                clk,
  input  logic                reset,
  up_debug_monitor_if.master  bus
);

  localparam int NUM_PAGES = num_pages(NUM_CH);
  localparam int PAGE_W    = page_w(NUM_CH);
  localparam int PRE_W     = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

  logic step_p, run_p, page_p;
  logic lvl_step, lvl_run, lvl_page;
  logic unused_levels;

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_step (
    .clk(clk), .reset(reset), .raw(bus.btn_step), .level(lvl_step), .pulse(step_p)
  );
  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_run (
    .clk(clk), .reset(reset), .raw(bus.btn_run), .level(lvl_run), .pulse(run_p)
  );
  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_page (
    .clk(clk), .reset(reset), .raw(bus.btn_page), .level(lvl_page), .pulse(page_p)
  );

  assign unused_levels = lvl_step ^ lvl_run ^ lvl_page;

  run_state_e        state, state_nxt;
  logic              cpu_en_q, cpu_en_nxt;
  logic              bp_hit_q, bp_hit_nxt;
  logic              skip_q, skip_nxt;
  logic [PRE_W-1:0]  presc_q, presc_nxt;
  logic [PAGE_W-1:0] page_q;
  logic              cand;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= HALT;
      cpu_en_q <= 1'b0;
      bp_hit_q <= 1'b0;
      skip_q   <= 1'b0;
      presc_q  <= '0;
      page_q   <= '0;
    end else begin
      state    <= state_nxt;
      cpu_en_q <= cpu_en_nxt;
      bp_hit_q <= bp_hit_nxt;
      skip_q   <= skip_nxt;
      presc_q  <= presc_nxt;
      if (page_p) begin
        page_q <= (int'(page_q) == NUM_PAGES - 1) ? '0 : page_q + 1'b1;
      end
    end
  end

  // Run pulses are decoded before step pulses, so a coincident step is lost.
  always_comb begin
    state_nxt  = state;
    cpu_en_nxt = 1'b0;
    bp_hit_nxt = bp_hit_q;
    skip_nxt   = skip_q;
    presc_nxt  = presc_q;
    cand       = (presc_q == PRE_W'(RUN_DIV - 1));
    case (state)
      HALT, BREAK: begin
        if (run_p) begin
          state_nxt  = RUN;
          presc_nxt  = '0;
          bp_hit_nxt = 1'b0;
          // leaving a breakpoint: let the core step off the matching PC
          skip_nxt   = (state == BREAK);
        end else if (step_p) begin
          state_nxt  = STEP;
          cpu_en_nxt = 1'b1;
          bp_hit_nxt = 1'b0;
        end
      end
      STEP: begin
        if (run_p) begin
          state_nxt = RUN;
          presc_nxt = '0;
          skip_nxt  = 1'b0;
        end else begin
          state_nxt = HALT;
        end
      end
      RUN: begin
        if (run_p) begin
          state_nxt = HALT;
        end else begin
          presc_nxt = cand ? '0 : presc_q + 1'b1;
          if (cand) begin
            skip_nxt = 1'b0;
            if (bus.bp_en && (bus.pc == bus.bp_addr) && !skip_q) begin
              state_nxt  = BREAK;
              bp_hit_nxt = 1'b1;
            end else begin
              cpu_en_nxt = 1'b1;
            end
          end
        end
      end
      default: state_nxt = HALT;
    endcase
  end

  // Channel selection for the three display slots; slots past NUM_CH blank.
  logic [2:0][7:0] ch_byte;
  logic [2:0]      ch_ok;

  always_comb begin
    ch_byte = '0;
    ch_ok   = '0;
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (int'(page_q) * 3 + s == k) begin
          ch_byte[s] = bus.probe[8*k +: 8];
          ch_ok[s]   = 1'b1;
        end
      end
    end
  end

  assign bus.hex5 = ch_ok[0] ? hex_to_seg(ch_byte[0][7:4]) : SEG_BLANK;
  assign bus.hex4 = ch_ok[0] ? hex_to_seg(ch_byte[0][3:0]) : SEG_BLANK;
  assign bus.hex3 = ch_ok[1] ? hex_to_seg(ch_byte[1][7:4]) : SEG_BLANK;
  assign bus.hex2 = ch_ok[1] ? hex_to_seg(ch_byte[1][3:0]) : SEG_BLANK;
  assign bus.hex1 = ch_ok[2] ? hex_to_seg(ch_byte[2][7:4]) : SEG_BLANK;
  assign bus.hex0 = ch_ok[2] ? hex_to_seg(ch_byte[2][3:0]) : SEG_BLANK;

  assign bus.cpu_en = cpu_en_q;
  assign bus.page   = page_q;
  assign bus.ledr   = {(state == RUN), bp_hit_q, bus.flags};

endmodule
